alu_serial: RTL and testbench

Parametrised, multi-cycle successor to the CPU's 8-bit ALU. It processes add, subtract, logic and rotate-right operations on WIDTH-bit operands, DIG nibbles per clock, behind a start/done handshake. It adds full BCD subtract correction and a wide-operand mode for multi-byte arithmetic and coprocessor use. It sits beside the core ALU on the datapath and honours the same RDY stall.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_serial_if.sv | 39 +++
 rtl/alu_nibble.sv | 54 +++++
 rtl/alu_serial.sv | 151 +++++++++++++++
 tb/tb_alu_serial.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// | Module : alu_pkg                                                        |
// | Brief  : Op codes, FSM state type and helpers shared by alu_serial.     |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_DBL  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nstep(input int width, input int dig);
    return width / (4 * dig);
  endfunction

  // Unlisted op codes collapse to pass-through.
  function automatic logic [3:0] norm_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_DBL, OP_OR, OP_AND, OP_XOR, OP_PASS: return op;
      default: return OP_PASS;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_if.sv
// ---------------------------------------------------------------------------
// | Module : alu_serial_if                                                  |
// | Brief  : Start/done handshake, operands and result bundle.              |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_serial_if #(
  parameter int WIDTH = 16
);
  logic             RDY;
  logic             start;
  logic [3:0]       op;
  logic             right;
  logic [WIDTH-1:0] AI;
  logic [WIDTH-1:0] BI;
  logic             CI;
  logic             BCD;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] OUT;
  logic             CO;
  logic             V;
  logic             Z;
  logic             N;
  logic             HC;

  modport master (
    output RDY, start, op, right, AI, BI, CI, BCD,
    input  busy, done, OUT, CO, V, Z, N, HC
  );

  modport slave (
    input  RDY, start, op, right, AI, BI, CI, BCD,
    output busy, done, OUT, CO, V, Z, N, HC
  );
endinterface

`default_nettype wire

// File: rtl/alu_nibble.sv
// ---------------------------------------------------------------------------
// | Module : alu_nibble                                                     |
// | Brief  : 4-bit slice: binary/BCD add and subtract, bitwise logic ops.   |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module alu_nibble
  import alu_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic [3:0] i_op,
  input  logic       i_bcd,
  output logic [3:0] o_r,
  output logic       o_cout,
  output logic       o_s3
);

  logic [3:0] w_bb;
  logic [4:0] w_sum;

  assign w_bb  = (i_op == OP_SUB) ? ~i_b : ((i_op == OP_DBL) ? i_a : i_b);
  assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {4'b0000, i_cin};
  assign o_s3  = w_sum[3];

  always_comb begin
    o_r    = i_a;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB, OP_DBL: begin
        o_r    = w_sum[3:0];
        o_cout = w_sum[4];
        if (i_bcd && (i_op == OP_ADD) && (w_sum > 5'd9)) begin
          o_r    = w_sum[3:0] + 4'd6;
          o_cout = 1'b1;
        end
        // A borrowing decimal digit wraps 0..15 back into 0..9.
        if (i_bcd && (i_op == OP_SUB) && !w_sum[4]) begin
          o_r    = w_sum[3:0] + 4'hA;
          o_cout = 1'b0;
        end
      end
      OP_OR:   o_r = i_a | i_b;
      OP_AND:  o_r = i_a & i_b;
      OP_XOR:  o_r = i_a ^ i_b;
      default: o_r = i_a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ---------------------------------------------------------------------------
// | Module : alu_serial                                                     |
// | Brief  : Multi-cycle nibble-serial ALU with start/done handshake.       |
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIG   = 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_serial_if.slave  bus
);

  localparam int NSTEP = nstep(WIDTH, DIG);
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int SW    = 4 * DIG;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_out;
  logic [3:0]       r_op;
  logic             r_bcd, r_right, r_c, r_hc_lat;
  logic             r_co, r_v, r_z, r_n, r_hc;
  logic             w_accept, w_last, w_busy, w_done;
  logic             w_arith, w_bb3, w_v, w_hc;
  logic [3:0]       w_op_in;
  logic [SW-1:0]    w_chunk;
  logic [DIG:0]     w_c;
  logic [DIG-1:0]   w_s3;
  logic [WIDTH-1:0] w_final;

  assign w_accept = bus.RDY && bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == CW'(NSTEP - 1));
  assign w_op_in  = norm_op(bus.op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (bus.RDY) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = bus.start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_c[0] = r_c;
  for (genvar gi = 0; gi < DIG; gi++) begin : g_nib
    alu_nibble u_nib (
      .i_a    (r_a[4*gi +: 4]),
      .i_b    (r_b[4*gi +: 4]),
      .i_cin  (w_c[gi]),
      .i_op   (r_op),
      .i_bcd  (r_bcd),
      .o_r    (w_chunk[4*gi +: 4]),
      .o_cout (w_c[gi+1]),
      .o_s3   (w_s3[gi])
    );
  end

  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_DBL);
  assign w_bb3   = (r_op == OP_SUB) ? ~r_b[SW-1] : ((r_op == OP_DBL) ? r_a[SW-1] : r_b[SW-1]);
  assign w_v     = w_arith && (r_a[SW-1] ^ w_s3[DIG-1]) && (w_bb3 ^ w_s3[DIG-1]);
  assign w_hc    = (r_cnt == '0) ? w_c[1] : r_hc_lat;
  assign w_final = (r_acc >> SW) | (WIDTH'(w_chunk) << (WIDTH - SW));

  // Rotate is pre-applied to the operand and then streamed as a pass op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_bcd    <= 1'b0;
      r_right  <= 1'b0;
      r_c      <= 1'b0;
      r_hc_lat <= 1'b0;
      r_out    <= '0;
      r_co     <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_hc     <= 1'b0;
    end else if (bus.RDY) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_b     <= bus.BI;
        r_acc   <= '0;
        r_bcd   <= bus.BCD;
        r_right <= bus.right;
        if (bus.right) begin
          r_a  <= {bus.CI, bus.AI[WIDTH-1:1]};
          r_op <= OP_PASS;
          r_c  <= bus.AI[0];
        end else begin
          r_a  <= bus.AI;
          r_op <= w_op_in;
          r_c  <= ((w_op_in == OP_ADD) || (w_op_in == OP_SUB)) ? bus.CI : 1'b0;
        end
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_a   <= r_a >> SW;
        r_b   <= r_b >> SW;
        r_acc <= w_final;
        if (!r_right) r_c <= w_c[DIG];
        if (r_cnt == '0) r_hc_lat <= w_c[1];
        if (w_last) begin
          r_out <= w_final;
          r_co  <= r_right ? r_c : w_c[DIG];
          r_v   <= w_v;
          r_z   <= (w_final == '0);
          r_n   <= w_final[WIDTH-1];
          r_hc  <= w_hc;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.OUT  = r_out;
  assign bus.CO   = r_co;
  assign bus.V    = r_v;
  assign bus.Z    = r_z;
  assign bus.N    = r_n;
  assign bus.HC   = r_hc;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ---------------------------------------------------------------------------
// | Module : tb_alu_serial                                                  |
// | Brief  : Directed vector table plus stall/abort sequences for alu_serial.|
// | Rev    : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_serial;
  import alu_pkg::*;

  typedef struct {
    bit          wide;
    logic [3:0]  op;
    logic        right;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        bcd;
    logic [31:0] out;
    logic        co;
    logic        v;
    logic        z;
    logic        n;
    logic        hc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(16)) if16 ();
  alu_serial_if #(.WIDTH(32)) if32 ();

  alu_serial #(.WIDTH(16), .DIG(1)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  alu_serial #(.WIDTH(32), .DIG(2)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wide, logic [3:0] op, logic right, logic [31:0] a, logic [31:0] b,
                              logic ci, logic bcd, logic [31:0] out,
                              logic co, logic v, logic z, logic n, logic hc);
    vec_t t;
    t.wide = wide; t.op = op; t.right = right; t.a = a; t.b = b; t.ci = ci; t.bcd = bcd;
    t.out = out; t.co = co; t.v = v; t.z = z; t.n = n; t.hc = hc;
    return t;
  endfunction

  task automatic run_vec(input vec_t t, input string nm);
    int   lat;
    logic d;
    @(negedge clk);
    if (t.wide) begin
      if32.op = t.op; if32.right = t.right; if32.AI = t.a; if32.BI = t.b;
      if32.CI = t.ci; if32.BCD = t.bcd; if32.start = 1'b1;
    end else begin
      if16.op = t.op; if16.right = t.right; if16.AI = t.a[15:0]; if16.BI = t.b[15:0];
      if16.CI = t.ci; if16.BCD = t.bcd; if16.start = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    if32.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      d = t.wide ? if32.done : if16.done;
      if (d) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_out"}, t.wide ? if32.OUT : 32'(if16.OUT), t.out);
    chk({nm, "_co"}, 32'(t.wide ? if32.CO : if16.CO), 32'(t.co));
    chk({nm, "_v"},  32'(t.wide ? if32.V  : if16.V),  32'(t.v));
    chk({nm, "_z"},  32'(t.wide ? if32.Z  : if16.Z),  32'(t.z));
    chk({nm, "_n"},  32'(t.wide ? if32.N  : if16.N),  32'(t.n));
    chk({nm, "_hc"}, 32'(t.wide ? if32.HC : if16.HC), 32'(t.hc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;

    reset = 1'b1;
    if16.RDY = 1'b1; if16.start = 1'b0; if16.op = OP_PASS; if16.right = 1'b0;
    if16.AI = '0; if16.BI = '0; if16.CI = 1'b0; if16.BCD = 1'b0;
    if32.RDY = 1'b1; if32.start = 1'b0; if32.op = OP_PASS; if32.right = 1'b0;
    if32.AI = '0; if32.BI = '0; if32.CI = 1'b0; if32.BCD = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(if16.busy), 32'd0);
    chk("rst_done", 32'(if16.done), 32'd0);
    chk("rst_out", 32'(if16.OUT), 32'd0);
    chk("rst_flags", 32'({if16.CO, if16.V, if16.Z, if16.N, if16.HC}), 32'd0);
    chk("rst_out32", if32.OUT, 32'd0);

    //             wide op       rt    a              b              ci    bcd   out            co v z n hc
    vecs.push_back(mk(0, OP_ADD,  1'b0, 32'h7FFF,     32'h0001,     1'b0, 1'b0, 32'h8000,     0, 1, 0, 1, 1));
    vecs.push_back(mk(0, OP_ADD,  1'b0, 32'h9999,     32'h0001,     1'b0, 1'b1, 32'h0000,     1, 0, 1, 0, 1));
    vecs.push_back(mk(0, OP_SUB,  1'b0, 32'h1000,     32'h0001,     1'b1, 1'b1, 32'h0999,     1, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB,  1'b0, 32'h0000,     32'h0001,     1'b1, 1'b1, 32'h9999,     0, 0, 0, 1, 0));
    vecs.push_back(mk(0, OP_ADD,  1'b1, 32'h0001,     32'h0000,     1'b1, 1'b0, 32'h8000,     1, 0, 0, 1, 0));
    vecs.push_back(mk(0, OP_XOR,  1'b0, 32'hF0F0,     32'hFFFF,     1'b0, 1'b0, 32'h0F0F,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB,  1'b0, 32'h0005,     32'h0003,     1'b1, 1'b0, 32'h0002,     1, 0, 0, 0, 1));
    vecs.push_back(mk(0, OP_DBL,  1'b0, 32'h4000,     32'h1234,     1'b1, 1'b0, 32'h8000,     0, 1, 0, 1, 0));
    vecs.push_back(mk(0, OP_AND,  1'b0, 32'hF0F0,     32'h3C3C,     1'b1, 1'b0, 32'h3030,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_OR,   1'b0, 32'h1200,     32'h0034,     1'b0, 1'b0, 32'h1234,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1'b0, 32'hABCD,     32'h1111,     1'b1, 1'b0, 32'hABCD,     0, 0, 0, 1, 0));
    vecs.push_back(mk(0, OP_ADD,  1'b0, 32'hFFFF,     32'h0000,     1'b1, 1'b0, 32'h0000,     1, 0, 1, 0, 1));
    vecs.push_back(mk(1, OP_ADD,  1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, OP_ADD,  1'b0, 32'h99999999, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1, 0, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // RDY held low on three edges mid-run stretches latency to 7.
    @(negedge clk);
    if16.op = OP_ADD; if16.right = 1'b0; if16.AI = 16'h0002; if16.BI = 16'h0003;
    if16.CI = 1'b0; if16.BCD = 1'b0; if16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        chk("stall_busy", 32'(if16.busy), 32'd1);
        chk("stall_nodone", 32'(if16.done), 32'd0);
      end
      if (if16.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
      if16.RDY = (k < 1) || (k >= 4);
    end
    chk("stall_latency", 32'(lat), 32'd7);
    chk("stall_out", 32'(if16.OUT), 32'h0005);
    @(negedge clk);
    if16.RDY = 1'b0;
    @(posedge clk);
    #1;
    chk("done_held", 32'(if16.done), 32'd1);
    @(negedge clk);
    if16.RDY = 1'b1;
    @(posedge clk);
    #1;
    chk("done_drop", 32'(if16.done), 32'd0);

    // start during busy is ignored; operands were latched at accept.
    @(negedge clk);
    if16.op = OP_ADD; if16.AI = 16'h0010; if16.BI = 16'h0020; if16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    ndone = 0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (if16.done) begin
        ndone++;
        if (lat < 0) lat = k;
        chk("busy_start_out", 32'(if16.OUT), 32'h0030);
      end
      @(negedge clk);
      if16.start = (k == 2);
      if (k == 2) if16.AI = 16'h0100;
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_latency", 32'(lat), 32'd4);

    // Asynchronous reset during step 2 clears everything at once.
    @(negedge clk);
    if16.op = OP_ADD; if16.AI = 16'hABCD; if16.BI = 16'h1111; if16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if16.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(if16.busy), 32'd0);
    chk("abort_done", 32'(if16.done), 32'd0);
    chk("abort_out", 32'(if16.OUT), 32'd0);
    chk("abort_flags", 32'({if16.CO, if16.V, if16.Z, if16.N, if16.HC}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (if16.done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_vec(mk(0, OP_ADD, 1'b0, 32'h0002, 32'h0003, 1'b0, 1'b0, 32'h0005, 0, 0, 0, 0, 0), "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
